// File: rtl/wptr_full_burst_if.sv
// Write-side bus of the burst write-pointer block: request, read-pointer input and status.
// WPTR_OVF_CLR_EN adds the overflow_clr request line.
interface wptr_full_burst_if #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned MAX_BURST  = 4
);
    localparam int unsigned NUM_W = $clog2(MAX_BURST + 1);

    logic                  winc;
    logic [NUM_W-1:0]      wnum;
    logic [ADDR_WIDTH:0]   rptr_sync;
    logic                  wack;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [ADDR_WIDTH:0]   wptr;
    logic [ADDR_WIDTH:0]   wfill;
    logic                  full;
    logic                  almost_full;
    logic                  overflow;
    logic                  wen_c;
`ifdef WPTR_OVF_CLR_EN
    logic                  overflow_clr;

    modport master (
        output winc, wnum, rptr_sync, overflow_clr,
        input  wack, waddr, wptr, wfill, full, almost_full, overflow, wen_c
    );
    modport slave (
        input  winc, wnum, rptr_sync, overflow_clr,
        output wack, waddr, wptr, wfill, full, almost_full, overflow, wen_c
    );
`else
    modport master (
        output winc, wnum, rptr_sync,
        input  wack, waddr, wptr, wfill, full, almost_full, overflow, wen_c
    );
    modport slave (
        input  winc, wnum, rptr_sync,
        output wack, waddr, wptr, wfill, full, almost_full, overflow, wen_c
    );
`endif
endinterface

// File: rtl/wptr_full_burst.sv
// Write-domain pointer/flag generator for a gray-pointer dual-clock FIFO, accepting 1..MAX_BURST words per request.
// Optional macro WPTR_OVF_CLR_EN adds a synchronous overflow clear.
module wptr_full_burst #(
    parameter int unsigned ADDR_WIDTH   = 4,
    parameter int unsigned MAX_BURST    = 4,
    parameter int unsigned AFULL_MARGIN = 2
) (
    input  logic            wclk,
    input  logic            wrst,
    wptr_full_burst_if.slave bus
);
    localparam int unsigned PW    = ADDR_WIDTH + 1;
    localparam int unsigned NUM_W = $clog2(MAX_BURST + 1);
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [PW-1:0]    DEPTH_P  = PW'(DEPTH);
    localparam logic [PW-1:0]    MARGIN_P = PW'(AFULL_MARGIN);
    localparam logic [NUM_W-1:0] MAXB_N   = NUM_W'(MAX_BURST);
    localparam logic             AF_RST   = (DEPTH <= AFULL_MARGIN);

    logic [PW-1:0]         r_wbin;
    logic [PW-1:0]         r_wptr;
    logic [ADDR_WIDTH-1:0] r_waddr;
    logic [PW-1:0]         r_wfill;
    logic                  r_full;
    logic                  r_afull;
    logic                  r_wack;
    logic                  r_ovf;

    logic [PW-1:0] w_rbin;
    logic [PW-1:0] w_free;
    logic [PW-1:0] w_num_p;
    logic [PW-1:0] w_wbin_next;
    logic [PW-1:0] w_fill_next;
    logic [PW-1:0] w_space_next;
    logic          w_req;
    logic          w_accept;
    logic          w_reject;
    logic          w_ovf_clr;

`ifdef WPTR_OVF_CLR_EN
    assign w_ovf_clr = bus.overflow_clr;
`else
    assign w_ovf_clr = 1'b0;
`endif

    // Gray to binary: each bit is the XOR of itself and all higher gray bits.
    always_comb begin
        w_rbin = '0;
        for (int i = 0; i < int'(PW); i++) begin
            w_rbin[i] = ^(bus.rptr_sync >> i);
        end
    end

    // Acceptance: all-or-nothing against the pessimistic free count.
    always_comb begin
        w_num_p      = PW'(bus.wnum);
        w_free       = DEPTH_P - (r_wbin - w_rbin);
        w_req        = bus.winc && (bus.wnum != '0);
        w_accept     = w_req && (bus.wnum <= MAXB_N) && (w_num_p <= w_free);
        w_reject     = w_req && !w_accept;
        w_wbin_next  = w_accept ? (r_wbin + w_num_p) : r_wbin;
        w_fill_next  = w_wbin_next - w_rbin;
        w_space_next = DEPTH_P - w_fill_next;
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            r_wbin  <= '0;
            r_wptr  <= '0;
            r_waddr <= '0;
            r_wfill <= '0;
            r_full  <= 1'b0;
            r_afull <= AF_RST;
            r_wack  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_wbin  <= w_wbin_next;
            r_wptr  <= w_wbin_next ^ (w_wbin_next >> 1);
            r_waddr <= w_wbin_next[ADDR_WIDTH-1:0];
            r_wfill <= w_fill_next;
            r_full  <= (w_fill_next == DEPTH_P);
            r_afull <= (w_space_next <= MARGIN_P);
            r_wack  <= w_accept;
            // A reject in the same cycle as a clear keeps the error visible.
            if (w_reject) begin
                r_ovf <= 1'b1;
            end else if (w_ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign bus.wack        = r_wack;
    assign bus.waddr       = r_waddr;
    assign bus.wptr        = r_wptr;
    assign bus.wfill       = r_wfill;
    assign bus.full        = r_full;
    assign bus.almost_full = r_afull;
    assign bus.overflow    = r_ovf;
    assign bus.wen_c       = w_accept && !wrst;
endmodule

// File: tb/tb_wptr_full_burst.sv
// Scoreboard bench for wptr_full_burst at ADDR_WIDTH=4, MAX_BURST=4, AFULL_MARGIN=2.
module tb_wptr_full_burst;
    localparam int unsigned AW = 4;
    localparam int unsigned MB = 4;
    localparam int unsigned AM = 2;

    typedef struct {
        int wack;
        int waddr;
        int wptr;
        int wfill;
        int full;
        int afull;
        int ovf;
    } exp_t;

    logic wclk;
    logic wrst;
    int   n_tests;
    int   n_fail;
    int   m_wbin;
    int   m_ovf;
    int   rb;
    exp_t sb[$];

    wptr_full_burst_if #(.ADDR_WIDTH(AW), .MAX_BURST(MB)) bus ();

    wptr_full_burst #(.ADDR_WIDTH(AW), .MAX_BURST(MB), .AFULL_MARGIN(AM)) dut (
        .wclk (wclk),
        .wrst (wrst),
        .bus  (bus.slave)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [AW:0] to_gray(input int b);
        logic [AW:0] v;
        v = (AW+1)'(b);
        return v ^ (v >> 1);
    endfunction

    // One write cycle: drive, model the next state, check combinational enable, then the registered outputs.
    task automatic cycle(input logic inc, input int num, input int rbin, input logic rst, input logic clr);
        exp_t e;
        exp_t g;
        int   fill;
        int   acc;
        int   req;
        bus.winc      = inc;
        bus.wnum      = 3'(num);
        bus.rptr_sync = to_gray(rbin);
        wrst          = rst;
`ifdef WPTR_OVF_CLR_EN
        bus.overflow_clr = clr;
`endif
        req = (inc && num != 0) ? 1 : 0;
        fill = (m_wbin - rbin) & 31;
        acc = (!rst && req != 0 && num <= int'(MB) && num <= 16 - fill) ? 1 : 0;
        if (rst) begin
            m_wbin = 0;
            m_ovf  = 0;
        end else begin
            if (acc != 0) m_wbin = (m_wbin + num) & 31;
            if (req != 0 && acc == 0) m_ovf = 1;
`ifdef WPTR_OVF_CLR_EN
            else if (clr) m_ovf = 0;
`endif
        end
        if (rst) begin
            e = '{0, 0, 0, 0, 0, 0, 0};
        end else begin
            fill     = (m_wbin - rbin) & 31;
            e.wack   = acc;
            e.waddr  = m_wbin & 15;
            e.wptr   = m_wbin ^ (m_wbin >> 1);
            e.wfill  = fill;
            e.full   = (fill == 16) ? 1 : 0;
            e.afull  = (16 - fill <= int'(AM)) ? 1 : 0;
            e.ovf    = m_ovf;
        end
        sb.push_back(e);
        #2;
        check("wen_c", int'(bus.wen_c), acc);
        @(posedge wclk);
        #1;
        if (sb.size() == 0) begin
            check("sb_empty", 1, 0);
        end else begin
            g = sb.pop_front();
            check("wack",  int'(bus.wack),        g.wack);
            check("waddr", int'(bus.waddr),       g.waddr);
            check("wptr",  int'(bus.wptr),        g.wptr);
            check("wfill", int'(bus.wfill),       g.wfill);
            check("full",  int'(bus.full),        g.full);
            check("afull", int'(bus.almost_full), g.afull);
            check("ovf",   int'(bus.overflow),    g.ovf);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        m_wbin  = 0;
        m_ovf   = 0;
        rb      = 0;
        wrst    = 1'b1;
        bus.winc = 1'b0;
        bus.wnum = '0;
        bus.rptr_sync = '0;
`ifdef WPTR_OVF_CLR_EN
        bus.overflow_clr = 1'b0;
`endif
        @(posedge wclk);
        #1;
        cycle(1'b0, 0, 0, 1'b1, 1'b0);
        cycle(1'b0, 0, 0, 1'b0, 1'b0);
        // Fill to full with four max bursts.
        for (int i = 0; i < 4; i++) cycle(1'b1, 4, 0, 1'b0, 1'b0);
        check("fill_full_wptr", int'(bus.wptr), 24);
        check("fill_full_flag", int'(bus.full), 1);
        cycle(1'b1, 1, 0, 1'b0, 1'b0);
        // Reads free three entries: four rejected, three accepted.
        cycle(1'b0, 0, 3, 1'b0, 1'b0);
        cycle(1'b1, 4, 3, 1'b0, 1'b0);
        cycle(1'b1, 3, 3, 1'b0, 1'b0);
        // Walk wbin to 30, then wrap across the pointer range.
        cycle(1'b1, 4, 19, 1'b0, 1'b0);
        cycle(1'b1, 4, 19, 1'b0, 1'b0);
        cycle(1'b1, 3, 19, 1'b0, 1'b0);
        cycle(1'b1, 3, 20, 1'b0, 1'b0);
        check("wrap_waddr", int'(bus.waddr), 1);
        check("wrap_wfill", int'(bus.wfill), 13);
        // Zero-word no-op and oversize reject from a clean state.
        cycle(1'b0, 0, 0, 1'b1, 1'b0);
        cycle(1'b1, 0, 0, 1'b0, 1'b0);
        cycle(1'b1, 5, 0, 1'b0, 1'b0);
        // Reset during a request.
        cycle(1'b1, 4, 0, 1'b1, 1'b0);
`ifdef WPTR_OVF_CLR_EN
        cycle(1'b1, 5, 0, 1'b0, 1'b0);
        cycle(1'b0, 0, 0, 1'b0, 1'b1);
        cycle(1'b1, 6, 0, 1'b0, 1'b1);
        cycle(1'b0, 0, 0, 1'b0, 1'b1);
`endif
        // Random traffic with a read pointer that trails the write pointer.
        rb = 0;
        for (int i = 0; i < 300; i++) begin
            int f;
            f  = (m_wbin - rb) & 31;
            rb = (rb + int'($urandom_range(0, f))) & 31;
            cycle(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 7)), rb,
                  1'($urandom_range(0, 60) == 0), 1'($urandom_range(0, 7) == 0));
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
